// File: rtl/voice_frame_scheduler.sv
// voice_frame_scheduler: sequences the ping-pong frame RAMs and output FIFO
// of the voice pitch-shift datapath.
// Write side: sample-driven addressing. A write to the last address swaps banks.
// Read side: one FSM (FILL/DRAIN/WAIT) reads a full frame from the idle bank
// using a fractional resampling pointer. It pushes into the FIFO under
// almost-full backpressure and pulses overrun if a swap arrives mid-drain.
// Optional build macro VOICE_SCHED_STATS_EN adds two counters:
//   frame_cnt   - completed drains, wraps
//   overrun_cnt - overruns, saturates at 255
// ram_rd_bank is always the complement of ram_wr_bank, including during reset.
module voice_frame_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int FRAC_WIDTH = 6,
  parameter int STEP_UP    = 80,
  parameter int STEP_DOWN  = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [1:0]            mode,
  input  logic                  fifo_almost_full,
  output logic                  ram_wr_en,
  output logic                  ram_wr_bank,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_rd_bank,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  fifo_wr_en,
  output logic                  busy,
  output logic                  overrun
`ifdef VOICE_SCHED_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            overrun_cnt
`endif
);

  localparam int PTR_W  = ADDR_WIDTH + FRAC_WIDTH;
  localparam int STEP_W = FRAC_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Resampling step in Q2.FRAC_WIDTH; modes 0 and 3 are unity (bypass).
  function automatic logic [STEP_W-1:0] step_for_mode(input logic [1:0] m);
    case (m)
      2'd1:    return STEP_W'(STEP_UP);
      2'd2:    return STEP_W'(STEP_DOWN);
      default: return STEP_W'(1) << FRAC_WIDTH;
    endcase
  endfunction

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_bank_q, wr_bank_d;
  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  fifo_wr_en_q;
  logic                  overrun_q, overrun_d;
  logic                  swap;
  logic                  rd_issue;
  logic                  last_read;
  logic                  load;

  // Swap fires on the write of the last frame address; the bank flips on that edge.
  assign swap      = sample_valid && (wr_addr_q == LAST_ADDR);
  assign rd_issue  = (state_q == S_DRAIN) && !fifo_almost_full;
  assign last_read = rd_issue && (rd_cnt_q == LAST_ADDR);

  // Write-side next state: free of the FSM, driven only by the sample strobe.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    if (sample_valid) wr_addr_d = wr_addr_q + 1'b1;
    if (swap)         wr_bank_d = ~wr_bank_q;
  end

  // Write-side state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // Drain FSM next state; a swap always wins and restarts the drain on the new bank.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    step_d    = step_q;
    overrun_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_FILL, S_WAIT: begin
        if (swap) begin
          state_d = S_DRAIN;
          load    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(step_q);
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (last_read) state_d = S_WAIT;
        if (swap) begin
          state_d   = S_DRAIN;
          load      = 1'b1;
          overrun_d = !last_read;
        end
      end
      default: state_d = S_FILL;
    endcase
    if (load) begin
      rd_ptr_d = '0;
      rd_cnt_d = '0;
      step_d   = step_for_mode(mode);
    end
  end

  // Drain FSM registers; the FIFO push is the read issue delayed by the RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      rd_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      step_q       <= STEP_W'(1) << FRAC_WIDTH;
      fifo_wr_en_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      step_q       <= step_d;
      fifo_wr_en_q <= rd_issue;
      overrun_q    <= overrun_d;
    end
  end

`ifdef VOICE_SCHED_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  overrun_cnt_q;

  // Statistics: completed drains wrap, overruns saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      if (last_read) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (overrun_d && (overrun_cnt_q != 8'hFF)) overrun_cnt_q <= overrun_cnt_q + 1'b1;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = overrun_cnt_q;
`endif

  assign ram_wr_en   = sample_valid;
  assign ram_wr_bank = wr_bank_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_rd_bank = ~wr_bank_q;
  assign ram_rd_addr = rd_ptr_q[PTR_W-1:FRAC_WIDTH];
  assign fifo_wr_en  = fifo_wr_en_q;
  assign busy        = (state_q == S_DRAIN);
  assign overrun     = overrun_q;

endmodule
